// File: rtl/term_pkg.sv
// Shared encodings for the terminal line editor: event types, controller states, blank cell code.
package term_pkg;

   typedef enum logic [1:0] {
      EV_CHAR  = 2'b00,
      EV_ENTER = 2'b01,
      EV_BKSP  = 2'b10,
      EV_NONE  = 2'b11
   } ev_type_e;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_EMIT,
      ST_CLEAR
   } state_e;

   localparam logic [7:0] SPACE_CHAR = 8'h20;

endpackage

// File: rtl/term_line_buffer.sv
// Captures the characters of the line being typed; writes append at len, reads are by index.
// Characters past MAX_LINE are dropped and flagged through a sticky trunc bit.
module term_line_buffer
   import term_pkg::*;
#(
   parameter  int MAX_LINE = 32,
   localparam int IW       = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1,
   localparam int LW       = $clog2(MAX_LINE + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_char,
   input  logic          del_en,
   input  logic          clr,
   input  logic [IW-1:0] rd_idx,
   output logic [7:0]    rd_char,
   output logic [LW-1:0] len,
   output logic          trunc
);

   logic [7:0] mem [MAX_LINE];
   logic       has_room;

   assign has_room = (len < LW'(MAX_LINE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len   <= '0;
         trunc <= 1'b0;
      end else if (clr) begin
         len   <= '0;
         trunc <= 1'b0;
      end else if (wr_en) begin
         if (has_room) begin
            len <= len + 1'b1;
         end else begin
            trunc <= 1'b1;
         end
      end else if (del_en && (len != '0)) begin
         len <= len - 1'b1;
      end
   end

   // Storage holds no state worth resetting; len alone defines what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !clr && has_room) begin
         mem[len[IW-1:0]] <= wr_char;
      end
   end

   assign rd_char = (int'(rd_idx) < MAX_LINE) ? mem[rd_idx] : SPACE_CHAR;

endmodule

// File: rtl/term_line_editor.sv
// Turns keyboard events into character-grid writes and streams completed lines downstream.
// Blanks the grid after reset, auto-wraps at the right edge and clears each new row before use.
module term_line_editor
   import term_pkg::*;
#(
   parameter  int SCREEN_WIDTH  = 76,
   parameter  int SCREEN_HEIGHT = 44,
   parameter  int MAX_LINE      = 32,
   parameter  int SCROLL_MODE   = 1,
   localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
   localparam int CW = $clog2(SCREEN_WIDTH),
   localparam int RW = $clog2(SCREEN_HEIGHT),
   localparam int IW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1,
   localparam int LW = $clog2(MAX_LINE + 1)
) (
   input  logic          pixel_clk_in,
   input  logic          rst_in,
   input  logic          ev_valid,
   output logic          ev_ready,
   input  logic [1:0]    ev_type,
   input  logic [7:0]    ev_char,
   output logic          tg_we,
   output logic [AW-1:0] tg_addr,
   output logic [7:0]    tg_input,
   output logic [CW-1:0] cursor_col,
   output logic [RW-1:0] cursor_row,
   output logic [RW-1:0] top_row,
   output logic          ln_valid,
   input  logic          ln_ready,
   output logic [7:0]    ln_char,
   output logic          ln_last,
   output logic          ln_trunc,
   output logic          busy
);

   state_e        state;
   logic [AW-1:0] init_addr;
   logic [CW-1:0] clr_col;
   logic [IW-1:0] emit_idx;
   logic          full;

   logic          acc;
   logic          lb_wr;
   logic          lb_del;
   logic          lb_clr;
   logic [IW-1:0] lb_rd_idx;
   logic [7:0]    lb_rd_char;
   logic [LW-1:0] lb_len;
   logic          lb_trunc;

   logic          row_wrap;
   logic [RW-1:0] row_next;
   logic [RW-1:0] top_next;
   logic          do_nl;

   function automatic logic [AW-1:0] grid_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return AW'(int'(r) * SCREEN_WIDTH + int'(c));
   endfunction

   // ev_ready is only ever high in IDLE, so acc implies IDLE.
   assign acc       = ev_valid & ev_ready;
   assign lb_wr     = acc && (ev_type == EV_CHAR);
   assign lb_del    = acc && (ev_type == EV_BKSP) && (cursor_col != '0);
   assign lb_clr    = (state == ST_EMIT) && ln_valid && ln_ready && ln_last;
   assign lb_rd_idx = (state == ST_EMIT) ? emit_idx + 1'b1 : '0;

   assign row_wrap = (cursor_row == RW'(SCREEN_HEIGHT - 1));
   assign row_next = row_wrap ? '0 : cursor_row + 1'b1;
   assign top_next = (SCROLL_MODE == 1 && (full || row_wrap))
                     ? ((row_next == RW'(SCREEN_HEIGHT - 1)) ? '0 : row_next + 1'b1)
                     : '0;

   // Every path that moves to a fresh row: right-edge wrap, empty enter, end of line stream.
   assign do_nl = (lb_wr && (cursor_col == CW'(SCREEN_WIDTH - 1)))
                | (acc && (ev_type == EV_ENTER) && (lb_len == '0))
                | lb_clr;

   term_line_buffer #(
      .MAX_LINE (MAX_LINE)
   ) u_line_buffer (
      .clk     (pixel_clk_in),
      .rst     (rst_in),
      .wr_en   (lb_wr),
      .wr_char (ev_char),
      .del_en  (lb_del),
      .clr     (lb_clr),
      .rd_idx  (lb_rd_idx),
      .rd_char (lb_rd_char),
      .len     (lb_len),
      .trunc   (lb_trunc)
   );

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= ST_INIT;
         ev_ready   <= 1'b0;
         tg_we      <= 1'b0;
         tg_addr    <= '0;
         tg_input   <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
         top_row    <= '0;
         ln_valid   <= 1'b0;
         ln_char    <= '0;
         ln_last    <= 1'b0;
         ln_trunc   <= 1'b0;
         busy       <= 1'b1;
         init_addr  <= '0;
         clr_col    <= '0;
         emit_idx   <= '0;
         full       <= 1'b0;
      end else begin
         tg_we <= 1'b0;
         case (state)
            ST_INIT: begin
               tg_we     <= 1'b1;
               tg_addr   <= init_addr;
               tg_input  <= SPACE_CHAR;
               init_addr <= init_addr + 1'b1;
               if (init_addr == AW'(SCREEN_WIDTH * SCREEN_HEIGHT - 1)) begin
                  state    <= ST_IDLE;
                  ev_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (acc) begin
                  case (ev_type)
                     EV_CHAR: begin
                        tg_we      <= 1'b1;
                        tg_addr    <= grid_addr(cursor_row, cursor_col);
                        tg_input   <= ev_char;
                        cursor_col <= cursor_col + 1'b1;
                     end
                     EV_BKSP: begin
                        if (cursor_col != '0) begin
                           tg_we      <= 1'b1;
                           tg_addr    <= grid_addr(cursor_row, cursor_col - 1'b1);
                           tg_input   <= SPACE_CHAR;
                           cursor_col <= cursor_col - 1'b1;
                        end
                     end
                     EV_ENTER: begin
                        if (lb_len != '0) begin
                           state    <= ST_EMIT;
                           ev_ready <= 1'b0;
                           busy     <= 1'b1;
                           ln_valid <= 1'b1;
                           ln_char  <= lb_rd_char;
                           ln_last  <= (lb_len == LW'(1));
                           ln_trunc <= lb_trunc;
                           emit_idx <= '0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_EMIT: begin
               if (ln_valid && ln_ready) begin
                  if (ln_last) begin
                     ln_valid <= 1'b0;
                     ln_last  <= 1'b0;
                     ln_trunc <= 1'b0;
                  end else begin
                     emit_idx <= emit_idx + 1'b1;
                     ln_char  <= lb_rd_char;
                     ln_last  <= (int'(emit_idx) + 2 == int'(lb_len));
                  end
               end
            end
            ST_CLEAR: begin
               tg_we    <= 1'b1;
               tg_addr  <= grid_addr(cursor_row, clr_col);
               tg_input <= SPACE_CHAR;
               clr_col  <= clr_col + 1'b1;
               if (clr_col == CW'(SCREEN_WIDTH - 1)) begin
                  state    <= ST_IDLE;
                  ev_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase

         // Placed after the case so it overrides the per-state cursor/state updates.
         if (do_nl) begin
            state      <= ST_CLEAR;
            ev_ready   <= 1'b0;
            busy       <= 1'b1;
            cursor_row <= row_next;
            cursor_col <= '0;
            clr_col    <= '0;
            full       <= full | row_wrap;
            top_row    <= top_next;
         end
      end
   end

endmodule

// File: tb/tb_term_line_editor.sv
// Scoreboard bench: a queue-based model predicts grid writes and line characters, a monitor checks them.
module tb_term_line_editor;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int ML = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_type;
   logic [7:0] ev_char;
   logic       tg_we;
   logic [3:0] tg_addr;
   logic [7:0] tg_input;
   logic [1:0] cursor_col;
   logic [1:0] cursor_row;
   logic [1:0] top_row;
   logic       ln_valid;
   logic       ln_ready;
   logic [7:0] ln_char;
   logic       ln_last;
   logic       ln_trunc;
   logic       busy;

   always #5 clk = ~clk;

   term_line_editor #(
      .SCREEN_WIDTH (W),
      .SCREEN_HEIGHT(H),
      .MAX_LINE     (ML),
      .SCROLL_MODE  (1)
   ) dut (
      .pixel_clk_in(clk),
      .rst_in      (rst),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_type     (ev_type),
      .ev_char     (ev_char),
      .tg_we       (tg_we),
      .tg_addr     (tg_addr),
      .tg_input    (tg_input),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .top_row     (top_row),
      .ln_valid    (ln_valid),
      .ln_ready    (ln_ready),
      .ln_char     (ln_char),
      .ln_last     (ln_last),
      .ln_trunc    (ln_trunc),
      .busy        (busy)
   );

   typedef struct {int addr; int data;} wr_t;
   typedef struct {int ch; int last; int trunc;} ln_t;

   wr_t wq[$];
   ln_t lq[$];

   int total = 0;
   int bad   = 0;

   // Reference model: cursor position, scroll state and the current line as a plain queue.
   int m_col, m_row, m_full, m_trunc;
   int m_line[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_wr(input int a, input int d);
      wr_t w;
      w.addr = a;
      w.data = d;
      wq.push_back(w);
   endtask

   task automatic m_newline();
      m_row = (m_row + 1) % H;
      if (m_row == 0) m_full = 1;
      m_col = 0;
      for (int k = 0; k < W; k++) push_wr(m_row * W + k, 'h20);
   endtask

   task automatic m_reset();
      m_col = 0; m_row = 0; m_full = 0; m_trunc = 0;
      m_line.delete();
      wq.delete();
      lq.delete();
      for (int a = 0; a < W * H; a++) push_wr(a, 'h20);
   endtask

   task automatic m_event(input int t, input int c);
      ln_t l;
      case (t)
         0: begin
            push_wr(m_row * W + m_col, c);
            if (m_line.size() < ML) m_line.push_back(c);
            else m_trunc = 1;
            if (m_col == W - 1) m_newline();
            else m_col++;
         end
         1: begin
            for (int i = 0; i < m_line.size(); i++) begin
               l.ch    = m_line[i];
               l.last  = (i == m_line.size() - 1) ? 1 : 0;
               l.trunc = m_trunc;
               lq.push_back(l);
            end
            m_line.delete();
            m_trunc = 0;
            m_newline();
         end
         2: begin
            if (m_col > 0) begin
               m_col--;
               push_wr(m_row * W + m_col, 'h20);
               if (m_line.size() > 0) void'(m_line.pop_back());
            end
         end
         default: ;
      endcase
   endtask

   // Monitor: every grid write and every line handshake is checked against the queues.
   wr_t mw;
   ln_t ml;
   int  hold_vld = 0;
   int  hold_char, hold_last;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_vld = 0;
         end else begin
            if (tg_we) begin
               if (wq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL spurious_write: addr=%0d data=%0d, expected no write", tg_addr, tg_input);
               end else begin
                  mw = wq.pop_front();
                  check("wr_addr", int'(tg_addr), mw.addr);
                  check("wr_data", int'(tg_input), mw.data);
               end
            end
            if (hold_vld != 0) begin
               check("ln_valid_held", int'(ln_valid), 1);
               check("ln_char_stable", int'(ln_char), hold_char);
               check("ln_last_stable", int'(ln_last), hold_last);
            end
            hold_vld = 0;
            if (ln_valid) begin
               if (ln_ready) begin
                  if (lq.size() == 0) begin
                     total++; bad++;
                     $display("FAIL spurious_line: char=%0d, expected no line output", ln_char);
                  end else begin
                     ml = lq.pop_front();
                     check("ln_char", int'(ln_char), ml.ch);
                     check("ln_last", int'(ln_last), ml.last);
                     check("ln_trunc", int'(ln_trunc), ml.trunc);
                  end
               end else begin
                  hold_vld  = 1;
                  hold_char = int'(ln_char);
                  hold_last = int'(ln_last);
               end
            end
         end
      end
   end

   // Downstream acceptance: mostly ready, with occasional long stalls.
   int stall = 0;
   initial begin
      ln_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall > 0) begin
            ln_ready = 1'b0;
            stall--;
         end else if ($urandom_range(0, 15) == 0) begin
            ln_ready = 1'b0;
            stall = 10;
         end else begin
            ln_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_ev_ready", int'(ev_ready), 0);
      check("rst_tg_we", int'(tg_we), 0);
      check("rst_tg_addr", int'(tg_addr), 0);
      check("rst_ln_valid", int'(ln_valid), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_cursor_col", int'(cursor_col), 0);
      check("rst_cursor_row", int'(cursor_row), 0);
      check("rst_top_row", int'(top_row), 0);
   endtask

   // Waits for ev_ready, checks the idle-state view against the model, then presents one event.
   task automatic issue(input int t, input int c);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ev_ready && guard < 500) begin
         ev_valid = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (!ev_ready) begin
         total++; bad++;
         $display("FAIL ev_ready_timeout: ev_ready=%0d after %0d cycles, expected 1", ev_ready, guard);
         return;
      end
      check("cursor_col", int'(cursor_col), m_col);
      check("cursor_row", int'(cursor_row), m_row);
      check("top_row", int'(top_row), (m_full != 0) ? (m_row + 1) % H : 0);
      check("idle_busy", int'(busy), 0);
      ev_valid = 1'b1;
      ev_type  = 2'(t);
      ev_char  = 8'(c);
      m_event(t, c);
   endtask

   int dir_t[16] = '{0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 2};
   int dir_c[16] = '{'h41, 'h42, 0, 0, 'h31, 'h32, 'h33, 'h34, 0, 'h5a, 0, 0, 0, 'h61, 'h62, 0};

   initial begin
      int r, t, c, g;
      rst      = 1'b1;
      ev_valid = 1'b0;
      ev_type  = 2'b00;
      ev_char  = 8'h00;
      m_reset();
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs();
      @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 16; i++) issue(dir_t[i], dir_c[i]);

      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            issue(0, 'h51);
            issue(1, 0);
            @(negedge clk);
            ev_valid = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
            m_reset();
            #1;
            check_reset_outputs();
            @(posedge clk);
            #2 rst = 1'b0;
         end
         r = $urandom_range(0, 99);
         if (r < 60) begin t = 0; c = $urandom_range('h21, 'h7e); end
         else if (r < 75) begin t = 2; c = 0; end
         else if (r < 88) begin t = 1; c = 0; end
         else begin t = 3; c = $urandom_range(0, 255); end
         issue(t, c);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            ev_valid = 1'b0;
         end
      end

      @(negedge clk);
      ev_valid = 1'b0;
      g = 0;
      while ((wq.size() != 0 || lq.size() != 0 || !ev_ready) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("drain_writes_left", wq.size(), 0);
      check("drain_lines_left", lq.size(), 0);
      check("final_cursor_col", int'(cursor_col), m_col);
      check("final_cursor_row", int'(cursor_row), m_row);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
